// File: rtl/operand_skid_buffer.sv
// Two-entry valid/ready skid buffer that registers the selected 16-bit operand ahead of the ALU.
// Define SKID_STALL_CNT_EN to add a saturating stall_count output.
module operand_skid_buffer #(
  parameter int WIDTH       = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef SKID_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_count
`endif
);

  // Handshake: a word moves on a rising edge where valid and ready are both high;
  // in_ready depends only on skid_v, so back-pressure never ripples combinationally upstream.
  logic             main_v;
  logic             skid_v;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic             accept;
  logic             drain;

  if (STALL_CNT_W < 1) begin : g_bad_stall_cnt_w
    $error("STALL_CNT_W must be at least 1");
  end

  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign accept    = in_valid & in_ready;
  assign drain     = main_v & out_ready;

  // Occupancy is encoded by {main_v, skid_v}; 2'b01 cannot be reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else begin
      case ({main_v, skid_v})
        2'b00: begin
          if (accept) begin
            main_d <= in_data;
            main_v <= 1'b1;
          end
        end
        2'b10: begin
          if (accept && drain) begin
            main_d <= in_data;
          end else if (accept) begin
            skid_d <= in_data;
            skid_v <= 1'b1;
          end else if (drain) begin
            main_v <= 1'b0;
          end
        end
        2'b11: begin
          if (drain) begin
            main_d <= skid_d;
            skid_v <= 1'b0;
          end
        end
        default: begin
          main_v <= main_v;
        end
      endcase
    end
  end

`ifdef SKID_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (main_v && !out_ready && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end
`endif

  skid_implies_main: assert property (@(posedge clk) disable iff (reset) skid_v |-> main_v);

endmodule
